// File: rtl/sysid_check_master.sv
// sysid_check_master: Avalon-MM read master that fetches the system-ID word
// (address 0) and build timestamp (address 1), compares them against the
// expected constants and holds the verdict until the next start pulse.
module sysid_check_master #(
    parameter logic [31:0] EXPECTED_ID    = 32'hACD51302,
    parameter logic [31:0] EXPECTED_TS    = 32'h54ACE2AE,
    parameter int unsigned CHECK_TS       = 1,
    parameter int unsigned READ_LATENCY   = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        LAT_ID,
        RD_TS,
        LAT_TS,
        DONE
    } state_t;

    localparam bit          NO_LAT   = (READ_LATENCY == 0);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] LAT_LAST = NO_LAT ? 16'd0 : 16'(READ_LATENCY - 1);

    state_t      state_q, state_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic [15:0] lat_cnt_q, lat_cnt_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        timeout_q, timeout_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;

    logic        rd_active;
    logic        accept;
    logic        tmo_hit;
    logic        finish;
    logic        abort_id;
    logic        abort_ts;

    assign rd_active   = (state_q == RD_ID) || (state_q == RD_TS);
    assign accept      = rd_active && !avm_waitrequest;
    // >= so an accept landing on the final allowed cycle still aborts in LAT_*
    assign tmo_hit     = (tmo_cnt_q >= TMO_LAST);

    assign avm_read    = rd_active;
    assign avm_address = (state_q == RD_TS) || (state_q == LAT_TS);
    assign busy        = (state_q == RD_ID) || (state_q == LAT_ID) ||
                         (state_q == RD_TS) || (state_q == LAT_TS);
    assign done        = done_q;
    assign pass        = pass_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout     = timeout_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;

    // Next-state, read sequencing, capture and verdict evaluation
    always_comb begin
        state_d    = state_q;
        tmo_cnt_d  = tmo_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        timeout_d  = timeout_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        finish     = 1'b0;
        abort_id   = 1'b0;
        abort_ts   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = RD_ID;
                    tmo_cnt_d  = '0;
                    lat_cnt_d  = '0;
                    pass_d     = 1'b0;
                    id_ok_d    = 1'b0;
                    ts_ok_d    = 1'b0;
                    timeout_d  = 1'b0;
                    id_value_d = '0;
                    ts_value_d = '0;
                end
            end
            RD_ID: begin
                if (accept) begin
                    if (NO_LAT) begin
                        id_value_d = avm_readdata;
                        state_d    = RD_TS;
                        tmo_cnt_d  = '0;
                    end else begin
                        state_d   = LAT_ID;
                        lat_cnt_d = '0;
                        tmo_cnt_d = tmo_cnt_q + 16'd1;
                    end
                end else if (tmo_hit) begin
                    abort_id = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            LAT_ID: begin
                if (lat_cnt_q == LAT_LAST) begin
                    id_value_d = avm_readdata;
                    state_d    = RD_TS;
                    tmo_cnt_d  = '0;
                end else if (tmo_hit) begin
                    abort_id = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q + 16'd1;
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            RD_TS: begin
                if (accept) begin
                    if (NO_LAT) begin
                        ts_value_d = avm_readdata;
                        finish     = 1'b1;
                    end else begin
                        state_d   = LAT_TS;
                        lat_cnt_d = '0;
                        tmo_cnt_d = tmo_cnt_q + 16'd1;
                    end
                end else if (tmo_hit) begin
                    abort_ts = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            LAT_TS: begin
                if (lat_cnt_q == LAT_LAST) begin
                    ts_value_d = avm_readdata;
                    finish     = 1'b1;
                end else if (tmo_hit) begin
                    abort_ts = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q + 16'd1;
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (finish || abort_id || abort_ts) begin
            state_d   = DONE;
            done_d    = 1'b1;
            timeout_d = abort_id || abort_ts;
            id_ok_d   = !abort_id && (id_value_d == EXPECTED_ID);
            ts_ok_d   = finish && ((CHECK_TS == 0) || (ts_value_d == EXPECTED_TS));
            pass_d    = id_ok_d && ts_ok_d && !timeout_d;
        end
    end

    // State and result registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            tmo_cnt_q  <= '0;
            lat_cnt_q  <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            timeout_q  <= 1'b0;
            id_value_q <= '0;
            ts_value_q <= '0;
        end else begin
            state_q    <= state_d;
            tmo_cnt_q  <= tmo_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            timeout_q  <= timeout_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
        end
    end

endmodule

// File: tb/tb_sysid_check_master.sv
// Scoreboard bench for sysid_check_master: two instances (default parameters,
// and CHECK_TS=0 / TIMEOUT_CYCLES=16) each driven by a small slave model.
module tb_sysid_check_master;

    typedef struct {
        logic        pass;
        logic        id_ok;
        logic        ts_ok;
        logic        tmo;
        logic [31:0] idv;
        logic [31:0] tsv;
        int          lat;
        int          rdc;
        int          t0;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t q0[$];
    exp_t q1[$];

    // DUT0 signals and slave model
    logic        start0, busy0, done0, pass0, id_ok0, ts_ok0, timeout0;
    logic [31:0] id_value0, ts_value0, rdata0;
    logic        addr0, read0, wait0;
    logic [31:0] id_w0, ts_w0;
    int          nwait0, wcnt0;
    bit          stuck0;

    assign wait0  = stuck0 || (read0 && (wcnt0 < nwait0));
    assign rdata0 = addr0 ? ts_w0 : id_w0;
    always @(posedge clock) begin
        if (reset || !read0 || !wait0) wcnt0 <= 0;
        else                           wcnt0 <= wcnt0 + 1;
    end

    // DUT1 signals and slave model
    logic        start1, busy1, done1, pass1, id_ok1, ts_ok1, timeout1;
    logic [31:0] id_value1, ts_value1, rdata1;
    logic        addr1, read1, wait1;
    logic [31:0] id_w1, ts_w1;
    int          nwait1, wcnt1;
    bit          stuck1;

    assign wait1  = stuck1 || (read1 && (wcnt1 < nwait1));
    assign rdata1 = addr1 ? ts_w1 : id_w1;
    always @(posedge clock) begin
        if (reset || !read1 || !wait1) wcnt1 <= 0;
        else                           wcnt1 <= wcnt1 + 1;
    end

    sysid_check_master dut0 (
        .clock(clock), .reset(reset), .start(start0), .busy(busy0), .done(done0),
        .pass(pass0), .id_ok(id_ok0), .ts_ok(ts_ok0), .timeout(timeout0),
        .id_value(id_value0), .ts_value(ts_value0), .avm_address(addr0),
        .avm_read(read0), .avm_waitrequest(wait0), .avm_readdata(rdata0)
    );

    sysid_check_master #(.CHECK_TS(0), .TIMEOUT_CYCLES(16)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .pass(pass1), .id_ok(id_ok1), .ts_ok(ts_ok1), .timeout(timeout1),
        .id_value(id_value1), .ts_value(ts_value1), .avm_address(addr1),
        .avm_read(read1), .avm_waitrequest(wait1), .avm_readdata(rdata1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic p, input logic io, input logic to, input logic tm,
                                input logic [31:0] iv, input logic [31:0] tv,
                                input int lat, input int rdc);
        exp_t e;
        e.pass = p; e.id_ok = io; e.ts_ok = to; e.tmo = tm;
        e.idv = iv; e.tsv = tv; e.lat = lat; e.rdc = rdc; e.t0 = 0;
        return e;
    endfunction

    task automatic cmp(input string tag, input exp_t e, input int rdc,
                       input logic p, input logic io, input logic to, input logic tm,
                       input logic [31:0] iv, input logic [31:0] tv);
        chk({tag, " pass"},     p,  e.pass);
        chk({tag, " id_ok"},    io, e.id_ok);
        chk({tag, " ts_ok"},    to, e.ts_ok);
        chk({tag, " timeout"},  tm, e.tmo);
        chk({tag, " id_value"}, iv, e.idv);
        chk({tag, " ts_value"}, tv, e.tsv);
        chk({tag, " done_latency"}, cyc - e.t0, e.lat);
        chk({tag, " read_cycles"},  rdc, e.rdc);
    endtask

    // DUT0 monitor: result scoreboard plus stall-stability and capture checks
    int   rdc0 = 0;
    logic p_stall0 = 1'b0;
    logic p_addr0  = 1'b0;
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            rdc0     = 0;
            p_stall0 = 1'b0;
        end else begin
            if (p_stall0) begin
                chk("dut0 read held in stall", read0, 1'b1);
                chk("dut0 address held in stall", addr0, p_addr0);
            end
            if (read0 && wait0 && !addr0) chk("dut0 id_value before accept", id_value0, 32'h0);
            if (read0 && wait0 && addr0)  chk("dut0 ts_value before accept", ts_value0, 32'h0);
            p_stall0 = read0 && wait0;
            p_addr0  = addr0;
            if (read0) rdc0++;
            if (done0) begin
                chk("dut0 done expected", q0.size() != 0, 1'b1);
                if (q0.size() != 0) begin
                    e = q0.pop_front();
                    cmp("dut0", e, rdc0, pass0, id_ok0, ts_ok0, timeout0, id_value0, ts_value0);
                    chk("dut0 busy low at done", busy0, 1'b0);
                end
                rdc0 = 0;
            end
        end
    end

    // DUT1 monitor: result scoreboard
    int rdc1 = 0;
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            rdc1 = 0;
        end else begin
            if (read1) rdc1++;
            if (done1) begin
                chk("dut1 done expected", q1.size() != 0, 1'b1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    cmp("dut1", e, rdc1, pass1, id_ok1, ts_ok1, timeout1, id_value1, ts_value1);
                end
                rdc1 = 0;
            end
        end
    end

    task automatic start0_pulse(input exp_t e, input bit push, input bit extra);
        exp_t x = e;
        @(posedge clock); #1;
        start0 = 1'b1;
        x.t0   = cyc;
        if (push) q0.push_back(x);
        @(posedge clock); #1;
        start0 = 1'b0;
        if (extra) begin
            start0 = 1'b1;
            @(posedge clock); #1;
            start0 = 1'b0;
        end
    endtask

    task automatic start1_pulse(input exp_t e);
        exp_t x = e;
        @(posedge clock); #1;
        start1 = 1'b1;
        x.t0   = cyc;
        q1.push_back(x);
        @(posedge clock); #1;
        start1 = 1'b0;
    endtask

    task automatic wait_done0(input int budget);
        logic seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            if (done0) seen = 1'b1;
        end
        chk("dut0 done within budget", seen, 1'b1);
    endtask

    task automatic wait_done1(input int budget);
        logic seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            if (done1) seen = 1'b1;
        end
        chk("dut1 done within budget", seen, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic seen;
        reset  = 1'b1;
        start0 = 1'b0; start1 = 1'b0;
        id_w0  = 32'hACD51302; ts_w0 = 32'h54ACE2AE; nwait0 = 0; stuck0 = 1'b0;
        id_w1  = 32'hACD51302; ts_w1 = 32'h0;        nwait1 = 0; stuck1 = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("reset busy",     busy0, 1'b0);
        chk("reset done",     done0, 1'b0);
        chk("reset pass",     pass0, 1'b0);
        chk("reset avm_read", read0, 1'b0);
        chk("reset address",  addr0, 1'b0);
        chk("reset id_value", id_value0, 32'h0);
        chk("reset ts_value", ts_value0, 32'h0);
        chk("reset dut1 timeout", timeout1, 1'b0);

        // Zero-wait good check, with a start pulse while busy that must be ignored
        start0_pulse(mk(1, 1, 1, 0, 32'hACD51302, 32'h54ACE2AE, 3, 2), 1, 1);
        wait_done0(20);

        // Wrong ID word
        id_w0 = 32'hDEADBEEF;
        start0_pulse(mk(0, 0, 1, 0, 32'hDEADBEEF, 32'h54ACE2AE, 3, 2), 1, 0);
        wait_done0(20);

        // Five wait states per read, started the cycle after the done pulse
        id_w0  = 32'hACD51302;
        nwait0 = 5;
        start0_pulse(mk(1, 1, 1, 0, 32'hACD51302, 32'h54ACE2AE, 13, 12), 1, 0);
        chk("restart id_value cleared", id_value0, 32'h0);
        chk("restart ts_value cleared", ts_value0, 32'h0);
        chk("restart ts_ok cleared",    ts_ok0, 1'b0);
        chk("restart busy",             busy0, 1'b1);
        chk("restart avm_read",         read0, 1'b1);
        chk("restart address",          addr0, 1'b0);
        wait_done0(40);

        // Reset during the timestamp read
        start0_pulse(mk(0, 0, 0, 0, 32'h0, 32'h0, 0, 0), 0, 0);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clock);
            if (addr0 && read0) seen = 1'b1;
        end
        chk("reach RD_TS", seen, 1'b1);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        chk("midreset avm_read", read0, 1'b0);
        chk("midreset address",  addr0, 1'b0);
        chk("midreset busy",     busy0, 1'b0);
        chk("midreset done",     done0, 1'b0);
        chk("midreset pass",     pass0, 1'b0);
        chk("midreset id_ok",    id_ok0, 1'b0);
        chk("midreset id_value", id_value0, 32'h0);
        nwait0 = 0;
        start0_pulse(mk(1, 1, 1, 0, 32'hACD51302, 32'h54ACE2AE, 3, 2), 1, 0);
        wait_done0(20);

        // CHECK_TS=0 with a zero timestamp
        start1_pulse(mk(1, 1, 1, 0, 32'hACD51302, 32'h0, 3, 2));
        wait_done1(20);

        // Slave stuck in waitrequest: timeout after 16 read cycles
        stuck1 = 1'b1;
        start1_pulse(mk(0, 0, 0, 1, 32'h0, 32'h0, 17, 16));
        wait_done1(40);
        repeat (6) @(negedge clock);
        chk("dut1 read dropped after timeout", read1, 1'b0);
        chk("dut1 timeout held", timeout1, 1'b1);

        chk("dut0 scoreboard drained", q0.size(), 0);
        chk("dut1 scoreboard drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
